// File: rtl/time_counter.sv
// Time-of-day counter: prescaled one-second tick, packed-BCD H:M:S,
// with pause, seconds clear and edge-triggered minute/hour adjust.
module time_counter #(
  parameter int DIV = 1000
) (
  input  logic       CP,
  input  logic       RST,
  input  logic       PAUSE,
  input  logic       SEC_CLR,
  input  logic       ADJ_M,
  input  logic       ADJ_H,
  output logic [7:0] TIME_H,
  output logic [7:0] TIME_M,
  output logic [7:0] TIME_S,
  output logic       TICK,
  output logic       HOUR_PULSE
);

  localparam logic [15:0] LAST = 16'(DIV - 1);

  logic [15:0] presc;
  logic        adj_m_q;
  logic        adj_h_q;
  logic        armed;
  logic        tick;
  logic        m_edge;
  logic        h_edge;
  logic        s_wrap;
  logic        h_carry;

  function automatic logic [7:0] bcd_inc(
    input logic [7:0] v,
    input logic [7:0] top
  );
    if (v == top)
      return 8'h00;
    if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // armed masks the first cycle after reset so a level held
  // through release is not mistaken for a fresh edge
  always_comb begin
    tick    = !SEC_CLR && !PAUSE && (presc == LAST);
    m_edge  = armed && ADJ_M && !adj_m_q;
    h_edge  = armed && ADJ_H && !adj_h_q;
    s_wrap  = tick && (TIME_S == 8'h59);
    h_carry = s_wrap && !m_edge && (TIME_M == 8'h59);
  end

  always_ff @(posedge CP or posedge RST) begin
    if (RST) begin
      presc   <= '0;
      adj_m_q <= 1'b0;
      adj_h_q <= 1'b0;
      armed   <= 1'b0;
    end else begin
      adj_m_q <= ADJ_M;
      adj_h_q <= ADJ_H;
      armed   <= 1'b1;
      if (SEC_CLR || tick)
        presc <= '0;
      else if (!PAUSE)
        presc <= presc + 16'd1;
    end
  end

  always_ff @(posedge CP or posedge RST) begin
    if (RST) begin
      TIME_H     <= 8'h00;
      TIME_M     <= 8'h00;
      TIME_S     <= 8'h00;
      TICK       <= 1'b0;
      HOUR_PULSE <= 1'b0;
    end else begin
      TICK       <= tick;
      HOUR_PULSE <= h_carry;
      if (SEC_CLR)
        TIME_S <= 8'h00;
      else if (tick)
        TIME_S <= bcd_inc(TIME_S, 8'h59);
      // an adjust edge absorbs a coincident tick carry
      if (m_edge || s_wrap)
        TIME_M <= bcd_inc(TIME_M, 8'h59);
      if (h_edge || h_carry)
        TIME_H <= bcd_inc(TIME_H, 8'h23);
    end
  end

endmodule

// File: tb/tb_time_counter.sv
// Scoreboard bench for time_counter: driver predicts each edge with an
// integer H:M:S model, monitor pops and compares after every edge.
module tb_time_counter;

  localparam int DIV = 4;

  logic       CP = 1'b0;
  logic       RST;
  logic       PAUSE;
  logic       SEC_CLR;
  logic       ADJ_M;
  logic       ADJ_H;
  logic [7:0] TIME_H;
  logic [7:0] TIME_M;
  logic [7:0] TIME_S;
  logic       TICK;
  logic       HOUR_PULSE;

  time_counter #(.DIV(DIV)) dut (
    .CP(CP),
    .RST(RST),
    .PAUSE(PAUSE),
    .SEC_CLR(SEC_CLR),
    .ADJ_M(ADJ_M),
    .ADJ_H(ADJ_H),
    .TIME_H(TIME_H),
    .TIME_M(TIME_M),
    .TIME_S(TIME_S),
    .TICK(TICK),
    .HOUR_PULSE(HOUR_PULSE)
  );

  always #5 CP = ~CP;

  typedef struct packed {
    logic [7:0] h;
    logic [7:0] m;
    logic [7:0] s;
    logic       tick;
    logic       hp;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  int mh, mm, ms, mp;
  bit pm, ph;

  function automatic logic [7:0] to_bcd(input int v);
    return 8'((v / 10) * 16 + v % 10);
  endfunction

  function automatic void model_reset();
    mh = 0;
    mm = 0;
    ms = 0;
    mp = 0;
    pm = ADJ_M;
    ph = ADJ_H;
  endfunction

  function automatic void predict();
    bit   em, eh, tk, cm, ch;
    exp_t e;
    em = ADJ_M && !pm;
    eh = ADJ_H && !ph;
    pm = ADJ_M;
    ph = ADJ_H;
    tk = 0;
    cm = 0;
    ch = 0;
    if (SEC_CLR) begin
      ms = 0;
      mp = 0;
    end else if (!PAUSE) begin
      if (mp == DIV - 1) begin
        mp = 0;
        tk = 1;
      end else begin
        mp++;
      end
    end
    if (tk) begin
      ms++;
      if (ms == 60) begin
        ms = 0;
        cm = 1;
      end
    end
    if (em) begin
      mm = (mm + 1) % 60;
    end else if (cm) begin
      mm++;
      if (mm == 60) begin
        mm = 0;
        ch = 1;
      end
    end
    if (eh || ch)
      mh = (mh + 1) % 24;
    e.h = to_bcd(mh);
    e.m = to_bcd(mm);
    e.s = to_bcd(ms);
    e.tick = tk;
    e.hp = ch;
    q.push_back(e);
  endfunction

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t",
               nm, act, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge CP);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("time_h", TIME_H, e.h);
        chk("time_m", TIME_M, e.m);
        chk("time_s", TIME_S, e.s);
        chk("tick", 8'(TICK), 8'(e.tick));
        chk("hour_pulse", 8'(HOUR_PULSE), 8'(e.hp));
      end
    end
  end

  task automatic step(input bit p, input bit c, input bit am,
                      input bit ah);
    @(posedge CP);
    #2;
    PAUSE = p;
    SEC_CLR = c;
    ADJ_M = am;
    ADJ_H = ah;
    predict();
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0);
  endtask

  task automatic pulse_m(input int n);
    repeat (n) begin
      step(0, 0, 1, 0);
      step(0, 0, 0, 0);
    end
  endtask

  task automatic pulse_h(input int n);
    repeat (n) begin
      step(0, 0, 0, 1);
      step(0, 0, 0, 0);
    end
  endtask

  // reset asserted and released between two rising edges
  task automatic async_reset();
    @(posedge CP);
    #3;
    RST = 1'b1;
    #1;
    chk("rst_h", TIME_H, 8'h00);
    chk("rst_m", TIME_M, 8'h00);
    chk("rst_s", TIME_S, 8'h00);
    chk("rst_tick", 8'(TICK), 8'h00);
    chk("rst_hp", 8'(HOUR_PULSE), 8'h00);
    RST = 1'b0;
    model_reset();
    predict();
  endtask

  task automatic run_to(input int s, input int p);
    for (int i = 0; i < 2000 && !(ms == s && mp == p); i++)
      step(0, 0, 0, 0);
  endtask

  initial begin : driver
    RST = 1'b1;
    PAUSE = 1'b0;
    SEC_CLR = 1'b0;
    ADJ_M = 1'b0;
    ADJ_H = 1'b0;
    repeat (3) @(posedge CP);
    #1;
    chk("init_h", TIME_H, 8'h00);
    chk("init_m", TIME_M, 8'h00);
    chk("init_s", TIME_S, 8'h00);
    chk("init_tick", 8'(TICK), 8'h00);
    chk("init_hp", 8'(HOUR_PULSE), 8'h00);
    @(negedge CP);
    RST = 1'b0;
    model_reset();
    predict();

    // one minute of ticks
    idle(60 * DIV);

    // preload 23:59:58 and roll over midnight
    async_reset();
    pulse_h(23);
    pulse_m(59);
    run_to(58, 0);
    idle(2 * DIV + 2);

    // minute adjust coincident with the 59 s tick at 10 min
    async_reset();
    pulse_m(10);
    run_to(59, DIV - 1);
    step(0, 0, 1, 0);
    idle(2);

    // hour adjust coincident with a minute-to-hour carry
    async_reset();
    pulse_h(5);
    pulse_m(59);
    run_to(59, DIV - 1);
    step(0, 0, 0, 1);
    idle(2);

    // pause while the prescaler sits at 2
    for (int i = 0; i < 100 && mp != 2; i++)
      step(0, 0, 0, 0);
    repeat (50) step(1, 0, 0, 0);
    idle(2 * DIV);

    // held hour adjust from 22
    async_reset();
    pulse_h(22);
    repeat (100) step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);

    // minute adjust held through reset release
    step(0, 0, 1, 0);
    async_reset();
    repeat (5) step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);

    // reset at 12:34:56, then seconds clear at 45
    async_reset();
    pulse_h(12);
    pulse_m(34);
    run_to(56, 1);
    async_reset();
    run_to(45, 2);
    step(0, 1, 0, 0);
    idle(3);
    step(1, 1, 1, 1);
    idle(2 * DIV);

    // randomized mix
    for (int i = 0; i < 4000; i++) begin
      bit p, c, am, ah;
      p  = ($urandom_range(0, 7) == 0);
      c  = ($urandom_range(0, 63) == 0);
      am = ($urandom_range(0, 5) == 0) ? !ADJ_M : ADJ_M;
      ah = ($urandom_range(0, 11) == 0) ? !ADJ_H : ADJ_H;
      step(p, c, am, ah);
    end

    @(posedge CP);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
